// File: rtl/tc_pl_cap_buff_sched.sv
// rtl/tc_pl_cap_buff_sched.sv - ping-pong capture buffer scheduler
// Alternates frames between two accumulation buffers and holds a buffer until readout frees it.
module tc_pl_cap_buff_sched #(
  parameter int FRM_W = 16,
  parameter int TO_W  = 32,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_start,
  input  logic             cap_stop,
  input  logic [FRM_W-1:0] cap_frame_num,
  input  logic [TO_W-1:0]  cap_timeout,
  output logic             buff_en,
  input  logic             buff_cmpt,
  output logic             buff_sel,
  output logic [1:0]       buff_full,
  input  logic [1:0]       rd_free,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             sched_busy,
  output logic             sched_done,
  output logic             sched_err
);

  localparam int GW = $clog2(GAP) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPT, S_GAP, S_DONE, S_ERR} state_t;

  state_t           state_q, state_d;
  logic             buff_en_q, buff_en_d;
  logic             buff_sel_q, buff_sel_d;
  logic [1:0]       buff_full_q, buff_full_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             sched_busy_q, sched_busy_d;
  logic             sched_done_q, sched_done_d;
  logic             sched_err_q, sched_err_d;
  logic             stop_pend_q, stop_pend_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [FRM_W-1:0] frame_num_q, frame_num_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic [1:0]       full_set;
  logic             full_clr_all;

  always_comb begin
    state_d      = state_q;
    buff_en_d    = buff_en_q;
    buff_sel_d   = buff_sel_q;
    frame_cnt_d  = frame_cnt_q;
    sched_done_d = 1'b0;
    sched_err_d  = sched_err_q;
    stop_pend_d  = stop_pend_q;
    timer_d      = timer_q;
    gap_cnt_d    = gap_cnt_q;
    frame_num_d  = frame_num_q;
    timeout_d    = timeout_q;
    full_set     = 2'b00;
    full_clr_all = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cap_start) begin
          state_d      = S_ARM;
          frame_num_d  = cap_frame_num;
          timeout_d    = cap_timeout;
          frame_cnt_d  = '0;
          buff_sel_d   = 1'b0;
          full_clr_all = 1'b1;
          sched_err_d  = 1'b0;
          stop_pend_d  = 1'b0;
        end
      end
      S_ARM: begin
        if (cap_stop) stop_pend_d = 1'b1;
        if (stop_pend_q) begin
          state_d      = S_DONE;
          sched_done_d = 1'b1;
        end else if (!buff_full_q[buff_sel_q]) begin
          state_d   = S_CAPT;
          buff_en_d = 1'b1;
          timer_d   = '0;
        end
      end
      S_CAPT: begin
        if (cap_stop) stop_pend_d = 1'b1;
        timer_d = timer_q + TO_W'(1);
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (buff_cmpt) begin
          buff_en_d            = 1'b0;
          full_set[buff_sel_q] = 1'b1;
          frame_cnt_d          = frame_cnt_q + FRM_W'(1);
          gap_cnt_d            = '0;
          state_d              = S_GAP;
        end else if ((timeout_q != '0) && (timer_q == timeout_q - TO_W'(1))) begin
          buff_en_d   = 1'b0;
          sched_err_d = 1'b1;
          state_d     = S_ERR;
        end
      end
      S_GAP: begin
        if (cap_stop) stop_pend_d = 1'b1;
        gap_cnt_d = gap_cnt_q + GW'(1);
        // Leave one cycle early: the ARM cycle supplies the final low cycle of the gap.
        if (gap_cnt_q == GW'(GAP - 2)) begin
          if (stop_pend_q || ((frame_num_q != '0) && (frame_cnt_q == frame_num_q))) begin
            state_d      = S_DONE;
            sched_done_d = 1'b1;
          end else begin
            buff_sel_d = ~buff_sel_q;
            state_d    = S_ARM;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (cap_stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    buff_full_d  = (full_clr_all ? 2'b00 : (buff_full_q | full_set)) & ~rd_free;
    sched_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      buff_en_q    <= 1'b0;
      buff_sel_q   <= 1'b0;
      buff_full_q  <= 2'b00;
      frame_cnt_q  <= '0;
      sched_busy_q <= 1'b0;
      sched_done_q <= 1'b0;
      sched_err_q  <= 1'b0;
      stop_pend_q  <= 1'b0;
      timer_q      <= '0;
      gap_cnt_q    <= '0;
      frame_num_q  <= '0;
      timeout_q    <= '0;
    end else begin
      state_q      <= state_d;
      buff_en_q    <= buff_en_d;
      buff_sel_q   <= buff_sel_d;
      buff_full_q  <= buff_full_d;
      frame_cnt_q  <= frame_cnt_d;
      sched_busy_q <= sched_busy_d;
      sched_done_q <= sched_done_d;
      sched_err_q  <= sched_err_d;
      stop_pend_q  <= stop_pend_d;
      timer_q      <= timer_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_num_q  <= frame_num_d;
      timeout_q    <= timeout_d;
    end
  end

  assign buff_en    = buff_en_q;
  assign buff_sel   = buff_sel_q;
  assign buff_full  = buff_full_q;
  assign frame_cnt  = frame_cnt_q;
  assign sched_busy = sched_busy_q;
  assign sched_done = sched_done_q;
  assign sched_err  = sched_err_q;

endmodule

// File: tb/tb_tc_pl_cap_buff_sched.sv
// tb/tb_tc_pl_cap_buff_sched.sv - scoreboard bench for the ping-pong capture scheduler
module tb_tc_pl_cap_buff_sched;
  localparam int FRM_W = 16;
  localparam int TO_W  = 32;
  localparam int GAP   = 2;
  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cap_start = 1'b0;
  logic             cap_stop = 1'b0;
  logic [FRM_W-1:0] cap_frame_num = '0;
  logic [TO_W-1:0]  cap_timeout = '0;
  logic             buff_en;
  logic             buff_cmpt = 1'b0;
  logic             buff_sel;
  logic [1:0]       buff_full;
  logic [1:0]       rd_free;
  logic [1:0]       rd_auto = 2'b00;
  logic [1:0]       rd_man = 2'b00;
  logic [FRM_W-1:0] frame_cnt;
  logic             sched_busy, sched_done, sched_err;

  assign rd_free = rd_auto | rd_man;

  tc_pl_cap_buff_sched #(.FRM_W(FRM_W), .TO_W(TO_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cap_start(cap_start), .cap_stop(cap_stop),
    .cap_frame_num(cap_frame_num), .cap_timeout(cap_timeout),
    .buff_en(buff_en), .buff_cmpt(buff_cmpt), .buff_sel(buff_sel),
    .buff_full(buff_full), .rd_free(rd_free), .frame_cnt(frame_cnt),
    .sched_busy(sched_busy), .sched_done(sched_done), .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int val;} exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   eng_delay = 0;
  int   eng_cnt = 0;
  bit   auto_free = 1'b0;
  bit   gap_check_en = 1'b0;
  int   fcnt [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int k, input int v);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) check("event_kind", k, e.kind);
      else check(k == EV_START ? "start_buff_sel" : (k == EV_DONE ? "done_frame_cnt" : "err_en_high_cycles"),
                 v, e.val);
    end
  endtask

  // Capture engine: raises buff_cmpt eng_delay cycles after buff_en rises (0 = never).
  initial begin
    forever begin
      @(negedge clk);
      if (!buff_en) begin
        buff_cmpt = 1'b0;
        eng_cnt   = 0;
      end else if (!buff_cmpt) begin
        eng_cnt++;
        if (eng_delay != 0 && eng_cnt == eng_delay) buff_cmpt = 1'b1;
      end
    end
  end

  // Readout: frees a full buffer 5 cycles after it is seen full.
  initial begin
    fcnt[0] = 0;
    fcnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rd_auto[i] = 1'b0;
        if (auto_free && buff_full[i]) begin
          if (fcnt[i] == 4) begin
            rd_auto[i] = 1'b1;
            fcnt[i] = 0;
          end else fcnt[i]++;
        end else fcnt[i] = 0;
      end
    end
  end

  logic prev_en = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
  int   hi_cnt = 0, lo_cnt = 0;
  bit   lo_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (buff_en && !prev_en) begin
        if (gap_check_en && lo_valid) check("gap_low_cycles", lo_cnt, GAP);
        lo_valid = 1'b0;
        hi_cnt = 1;
        pop_cmp(EV_START, int'(buff_sel));
      end else if (buff_en) hi_cnt++;
      if (!buff_en && prev_en) begin
        lo_cnt = 1;
        lo_valid = sched_busy;
      end else if (!buff_en) lo_cnt++;
      if (!sched_busy) lo_valid = 1'b0;
      if (sched_done && !prev_done) pop_cmp(EV_DONE, int'(frame_cnt));
      if (sched_err && !prev_err) pop_cmp(EV_ERR, hi_cnt);
      prev_en = buff_en;
      prev_done = sched_done;
      prev_err = sched_err;
    end
  end

  function automatic bit cond(input int what, input int arg);
    case (what)
      0: return sched_done;
      1: return sched_err;
      2: return (int'(frame_cnt) == arg) && buff_en;
      default: return int'(frame_cnt) == arg;
    endcase
  endfunction

  task automatic wait_until(input int what, input int arg, input string name);
    int n = 0;
    while (!cond(what, arg) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cond(what, arg)) check(name, 0, 1);
  endtask

  task automatic start(input int fn, input int to);
    @(negedge clk);
    cap_frame_num = FRM_W'(fn);
    cap_timeout = TO_W'(to);
    cap_start = 1'b1;
    @(negedge clk);
    cap_start = 1'b0;
  endtask

  task automatic stop();
    @(negedge clk);
    cap_stop = 1'b1;
    @(negedge clk);
    cap_stop = 1'b0;
  endtask

  task automatic finish_done(input string name);
    wait_until(0, 0, name);
    @(negedge clk);
    check({name, "_pulse_width"}, int'(sched_done), 0);
    check({name, "_busy_after"}, int'(sched_busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_buff_en", int'(buff_en), 0);
    check("rst_buff_full", int'(buff_full), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_buff_sel", int'(buff_sel), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_busy", int'(sched_busy), 0);
    check("rst_done", int'(sched_done), 0);
    check("rst_err", int'(sched_err), 0);

    // 1: three frames, readout frees promptly
    eng_delay = 20; auto_free = 1'b1; gap_check_en = 1'b1;
    push(EV_START, 0); push(EV_START, 1); push(EV_START, 0); push(EV_DONE, 3);
    start(3, 0);
    check("t1_busy", int'(sched_busy), 1);
    finish_done("t1_done");
    check("t1_frame_cnt", int'(frame_cnt), 3);
    gap_check_en = 1'b0;
    repeat (10) @(negedge clk);
    check("t1_drained", int'(buff_full), 0);

    // 2: readout stalls, scheduler parks in ARM
    auto_free = 1'b0;
    push(EV_START, 0); push(EV_START, 1);
    start(4, 0);
    wait_until(3, 2, "t2_two_frames");
    repeat (10) @(negedge clk);
    check("t2_full_parked", int'(buff_full), 3);
    check("t2_en_parked", int'(buff_en), 0);
    check("t2_busy_parked", int'(sched_busy), 1);
    push(EV_START, 0); push(EV_DONE, 3);
    @(negedge clk);
    rd_man = 2'b01;
    @(negedge clk);
    rd_man = 2'b00;
    check("t2_full_after_free", int'(buff_full), 2);
    check("t2_en_before", int'(buff_en), 0);
    @(negedge clk);
    check("t2_en_resume", int'(buff_en), 1);
    wait_until(3, 3, "t2_three_frames");
    repeat (5) @(negedge clk);
    check("t2_full_parked2", int'(buff_full), 3);
    stop();
    finish_done("t2_done");
    check("t2_full_retained", int'(buff_full), 3);
    @(negedge clk);
    rd_man = 2'b11;
    @(negedge clk);
    rd_man = 2'b00;
    check("t2_full_cleared", int'(buff_full), 0);

    // 3: watchdog
    eng_delay = 0; auto_free = 1'b1;
    push(EV_START, 0); push(EV_ERR, 50);
    start(0, 50);
    wait_until(1, 0, "t3_err_seen");
    check("t3_busy_err", int'(sched_busy), 1);
    check("t3_en_err", int'(buff_en), 0);
    check("t3_full_err", int'(buff_full), 0);
    start(1, 0);
    repeat (3) @(negedge clk);
    check("t3_start_ignored_busy", int'(sched_busy), 1);
    check("t3_start_ignored_err", int'(sched_err), 1);
    check("t3_start_ignored_en", int'(buff_en), 0);
    stop();
    check("t3_idle_after_stop", int'(sched_busy), 0);
    check("t3_err_sticky", int'(sched_err), 1);
    eng_delay = 20;
    push(EV_START, 0); push(EV_DONE, 1);
    start(1, 0);
    check("t3_err_cleared", int'(sched_err), 0);
    finish_done("t3_done");

    // 4: continuous mode, stop during frame 7
    push(EV_START, 0); push(EV_START, 1); push(EV_START, 0); push(EV_START, 1);
    push(EV_START, 0); push(EV_START, 1); push(EV_START, 0); push(EV_DONE, 7);
    start(0, 0);
    wait_until(2, 6, "t4_frame7_capt");
    repeat (5) @(negedge clk);
    stop();
    finish_done("t4_done");
    check("t4_frame_cnt", int'(frame_cnt), 7);

    // 5: completion and watchdog collide
    eng_delay = 20;
    push(EV_START, 0); push(EV_DONE, 1);
    start(1, 20);
    finish_done("t5_done");
    check("t5_err", int'(sched_err), 0);
    check("t5_frame_cnt", int'(frame_cnt), 1);

    // 6: async reset mid-frame
    auto_free = 1'b0;
    push(EV_START, 0); push(EV_START, 1);
    start(0, 0);
    wait_until(2, 1, "t6_frame2_capt");
    repeat (5) @(negedge clk);
    check("t6_full_pre", int'(buff_full), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_en", int'(buff_en), 0);
    check("t6_rst_full", int'(buff_full), 0);
    check("t6_rst_frame_cnt", int'(frame_cnt), 0);
    check("t6_rst_busy", int'(sched_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    auto_free = 1'b1;
    push(EV_START, 0); push(EV_DONE, 1);
    start(1, 0);
    finish_done("t6_done");
    check("t6_frame_cnt", int'(frame_cnt), 1);
    check("t6_err", int'(sched_err), 0);

    repeat (5) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
